// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB): 3-5 cycles per instruction, no backpressure
// except CTRL_MEM_WAIT_EN, which stalls MEM on i_mem_ack and bus-errors after MEM_TIMEOUT cycles.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_instr,
    input  logic        i_br_lt,
    input  logic        i_br_eq,
    input  logic        i_mem_ack,
    output logic        o_pc_en,
    output logic        o_ir_en,
    output logic        o_pc_sel,
    output logic [3:0]  o_imm_sel,
    output logic        o_reg_wen,
    output logic        o_br_un,
    output logic        o_a_sel,
    output logic        o_b_sel,
    output logic [1:0]  o_alu_op,
    output logic [3:0]  o_load_type,
    output logic        o_load_signed,
    output logic        o_mem_rw,
    output logic [1:0]  o_wb_sel,
    output logic        o_lui_sel,
    output logic        o_insn_vld,
    output logic        o_illegal,
    output logic        o_bus_err
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
    typedef enum logic [3:0] {C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC} cls_t;

    state_t      state, state_nxt;
    cls_t        cls, dec_cls;
    logic        started;
    logic        dec_illegal;
    logic        taken;
    logic        mem_done;
    logic        mem_tmo;
    logic [7:0]  wait_cnt;
    logic [3:0]  lt_dec;
    logic [6:0]  opcode;
    logic [2:0]  funct3;

    assign opcode = i_instr[6:0];
    assign funct3 = i_instr[14:12];

`ifdef CTRL_MEM_WAIT_EN
    logic unused_bits;
    assign unused_bits = &{1'b0, i_instr[31:15], i_instr[11:7]};
    assign mem_done    = i_mem_ack;
    assign mem_tmo     = !i_mem_ack && (wait_cnt == 8'(MEM_TIMEOUT - 1));
`else
    logic unused_bits;
    assign unused_bits = &{1'b0, i_mem_ack, wait_cnt, 8'(MEM_TIMEOUT), i_instr[31:15], i_instr[11:7]};
    assign mem_done    = 1'b1;
    assign mem_tmo     = 1'b0;
`endif

    always_comb begin
        dec_cls     = C_R;
        dec_illegal = 1'b0;
        case (opcode)
            OP_R:      dec_cls = C_R;
            OP_I:      dec_cls = C_I;
            OP_LOAD:   dec_cls = C_LOAD;
            OP_STORE:  dec_cls = C_STORE;
            OP_BRANCH: begin
                dec_cls     = C_BRANCH;
                dec_illegal = (funct3[2:1] == 2'b01);
            end
            OP_JAL:    dec_cls = C_JAL;
            OP_JALR:   dec_cls = C_JALR;
            OP_LUI:    dec_cls = C_LUI;
            OP_AUIPC:  dec_cls = C_AUIPC;
            default:   dec_illegal = 1'b1;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:         taken = i_br_eq;
            3'b001:         taken = !i_br_eq;
            3'b100, 3'b110: taken = i_br_lt;
            3'b101, 3'b111: taken = !i_br_lt;
            default:        taken = 1'b0;
        endcase
    end

    always_comb begin
        lt_dec = 4'b0000;
        case (funct3[1:0])
            2'b00:   lt_dec = 4'b0001;
            2'b01:   lt_dec = 4'b0011;
            2'b10:   lt_dec = 4'b1111;
            default: lt_dec = 4'b0000;
        endcase
    end

    // started holds FETCH quiet until the first edge after reset release
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state    <= S_FETCH;
            cls      <= C_R;
            started  <= 1'b0;
            wait_cnt <= 8'd0;
        end else begin
            state   <= state_nxt;
            started <= 1'b1;
            if (state == S_DECODE) cls <= dec_cls;
            if (state == S_MEM && !mem_done && !mem_tmo) wait_cnt <= wait_cnt + 8'd1;
            else                                         wait_cnt <= 8'd0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:  if (started) state_nxt = S_DECODE;
            S_DECODE: state_nxt = dec_illegal ? S_FETCH : S_EXEC;
            S_EXEC: begin
                case (cls)
                    C_BRANCH:        state_nxt = S_FETCH;
                    C_LOAD, C_STORE: state_nxt = S_MEM;
                    default:         state_nxt = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem_tmo)       state_nxt = S_FETCH;
                else if (mem_done) state_nxt = (cls == C_LOAD) ? S_WB : S_FETCH;
            end
            S_WB:     state_nxt = S_FETCH;
            default:  state_nxt = S_FETCH;
        endcase
    end

    always_comb begin
        o_pc_en       = 1'b0;
        o_ir_en       = 1'b0;
        o_pc_sel      = 1'b0;
        o_imm_sel     = 4'b0000;
        o_reg_wen     = 1'b0;
        o_br_un       = 1'b0;
        o_a_sel       = 1'b0;
        o_b_sel       = 1'b0;
        o_alu_op      = 2'b00;
        o_load_type   = 4'b0000;
        o_load_signed = 1'b0;
        o_mem_rw      = 1'b0;
        o_wb_sel      = 2'b00;
        o_lui_sel     = 1'b0;
        o_insn_vld    = 1'b0;
        o_illegal     = 1'b0;
        o_bus_err     = 1'b0;

        if (state inside {S_EXEC, S_MEM, S_WB}) begin
            o_wb_sel = 2'b01;
            case (cls)
                C_R:      o_alu_op = 2'b10;
                C_I: begin
                    o_b_sel  = 1'b1;
                    o_alu_op = 2'b11;
                end
                C_LOAD: begin
                    o_b_sel       = 1'b1;
                    o_wb_sel      = 2'b00;
                    o_load_type   = lt_dec;
                    o_load_signed = ~funct3[2];
                end
                C_STORE: begin
                    o_imm_sel     = 4'b0001;
                    o_b_sel       = 1'b1;
                    o_load_type   = lt_dec;
                    o_load_signed = ~funct3[2];
                end
                C_BRANCH: begin
                    o_imm_sel = 4'b0010;
                    o_a_sel   = 1'b1;
                    o_b_sel   = 1'b1;
                    o_br_un   = funct3[1];
                end
                C_JAL: begin
                    o_imm_sel = 4'b0100;
                    o_a_sel   = 1'b1;
                    o_b_sel   = 1'b1;
                    o_wb_sel  = 2'b10;
                end
                C_JALR: begin
                    o_b_sel  = 1'b1;
                    o_wb_sel = 2'b10;
                end
                C_LUI: begin
                    o_imm_sel = 4'b1000;
                    o_b_sel   = 1'b1;
                    o_lui_sel = 1'b1;
                end
                C_AUIPC: begin
                    o_imm_sel = 4'b1000;
                    o_a_sel   = 1'b1;
                    o_b_sel   = 1'b1;
                end
                default: ;
            endcase
        end

        case (state)
            S_FETCH:  o_ir_en = started;
            S_DECODE: if (dec_illegal) begin
                o_illegal = 1'b1;
                o_pc_en   = 1'b1;
            end
            S_EXEC:   if (cls == C_BRANCH) begin
                o_pc_en    = 1'b1;
                o_pc_sel   = taken;
                o_insn_vld = 1'b1;
            end
            S_MEM: begin
                o_mem_rw = (cls == C_STORE);
                if (mem_tmo) begin
                    o_bus_err = 1'b1;
                    o_pc_en   = 1'b1;
                end else if (mem_done && cls == C_STORE) begin
                    o_pc_en    = 1'b1;
                    o_insn_vld = 1'b1;
                end
            end
            S_WB: begin
                o_reg_wen  = 1'b1;
                o_pc_en    = 1'b1;
                o_insn_vld = 1'b1;
                o_pc_sel   = (cls == C_JAL) || (cls == C_JALR);
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: full output vector compared every cycle against hand-derived values.
module tb_multicycle_ctrl;
    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic [31:0] i_instr = 32'h0;
    logic        i_br_lt = 1'b0;
    logic        i_br_eq = 1'b0;
    logic        i_mem_ack = 1'b0;
    logic        o_pc_en, o_ir_en, o_pc_sel, o_reg_wen, o_br_un, o_a_sel, o_b_sel;
    logic        o_load_signed, o_mem_rw, o_lui_sel, o_insn_vld, o_illegal, o_bus_err;
    logic [3:0]  o_imm_sel, o_load_type;
    logic [1:0]  o_alu_op, o_wb_sel;

    always #5 i_clk = ~i_clk;

    multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_instr(i_instr), .i_br_lt(i_br_lt),
        .i_br_eq(i_br_eq), .i_mem_ack(i_mem_ack), .o_pc_en(o_pc_en), .o_ir_en(o_ir_en),
        .o_pc_sel(o_pc_sel), .o_imm_sel(o_imm_sel), .o_reg_wen(o_reg_wen), .o_br_un(o_br_un),
        .o_a_sel(o_a_sel), .o_b_sel(o_b_sel), .o_alu_op(o_alu_op), .o_load_type(o_load_type),
        .o_load_signed(o_load_signed), .o_mem_rw(o_mem_rw), .o_wb_sel(o_wb_sel),
        .o_lui_sel(o_lui_sel), .o_insn_vld(o_insn_vld), .o_illegal(o_illegal), .o_bus_err(o_bus_err)
    );

    logic [24:0] outs;
    assign outs = {o_pc_en, o_ir_en, o_pc_sel, o_imm_sel, o_reg_wen, o_br_un, o_a_sel, o_b_sel,
                   o_alu_op, o_load_type, o_load_signed, o_mem_rw, o_wb_sel, o_lui_sel,
                   o_insn_vld, o_illegal, o_bus_err};

    localparam logic [24:0] PC_EN   = 25'(1) << 24;
    localparam logic [24:0] IR_EN   = 25'(1) << 23;
    localparam logic [24:0] PC_SEL  = 25'(1) << 22;
    localparam logic [24:0] REG_WEN = 25'(1) << 17;
    localparam logic [24:0] BR_UN   = 25'(1) << 16;
    localparam logic [24:0] A_SEL   = 25'(1) << 15;
    localparam logic [24:0] B_SEL   = 25'(1) << 14;
    localparam logic [24:0] LSGN    = 25'(1) << 7;
    localparam logic [24:0] MEM_RW  = 25'(1) << 6;
    localparam logic [24:0] LUI     = 25'(1) << 3;
    localparam logic [24:0] VLD     = 25'(1) << 2;
    localparam logic [24:0] ILL     = 25'(1) << 1;
    localparam logic [24:0] BERR    = 25'(1);
    localparam logic [24:0] V_F     = IR_EN;
    localparam logic [24:0] RET     = PC_EN | REG_WEN | VLD;

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

    int checks = 0;
    int failures = 0;
    int retired = 0;

    always @(negedge i_clk) if (o_insn_vld === 1'b1) retired++;

    function automatic logic [24:0] imm_f(input logic [3:0] x); return 25'(x) << 18; endfunction
    function automatic logic [24:0] alu_f(input logic [1:0] x); return 25'(x) << 12; endfunction
    function automatic logic [24:0] lt_f(input logic [3:0] x);  return 25'(x) << 8;  endfunction
    function automatic logic [24:0] wb_f(input logic [1:0] x);  return 25'(x) << 4;  endfunction
    function automatic logic [31:0] ins(input logic [2:0] f3, input logic [6:0] op);
        return {12'h5A5, 5'd3, f3, 5'd1, op};
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        #2 i_reset = 1'b0;
        i_instr = ins(3'b000, OP_R);
        repeat (3) step();
        checks++;
        if (outs !== 25'h0) begin failures++; $display("FAIL reset_hold got=%h exp=%h", outs, 25'h0); end
        i_reset = 1'b1;
        #1;
        checks++;
        if (outs !== 25'h0) begin failures++; $display("FAIL reset_release got=%h exp=%h", outs, 25'h0); end
        step();
        checks++;
        if (outs !== V_F) begin failures++; $display("FAIL first_fetch got=%h exp=%h", outs, V_F); end
    endtask

    task automatic test_alu();
        logic [31:0] prog [4];
        logic [24:0] ex [4];
        logic [24:0] seq [4];
        prog[0] = ins(3'b000, OP_R);     ex[0] = alu_f(2'b10) | wb_f(2'b01);
        prog[1] = ins(3'b000, OP_I);     ex[1] = B_SEL | alu_f(2'b11) | wb_f(2'b01);
        prog[2] = ins(3'b000, OP_LUI);   ex[2] = imm_f(4'b1000) | B_SEL | LUI | wb_f(2'b01);
        prog[3] = ins(3'b000, OP_AUIPC); ex[3] = imm_f(4'b1000) | A_SEL | B_SEL | wb_f(2'b01);
        for (int n = 0; n < 4; n++) begin
            i_instr = prog[n];
            seq[0] = 25'h0; seq[1] = ex[n]; seq[2] = ex[n] | RET; seq[3] = V_F;
            for (int k = 0; k < 4; k++) begin
                step();
                checks++;
                if (outs !== seq[k]) begin
                    failures++;
                    $display("FAIL alu n%0d cyc%0d got=%h exp=%h", n, k, outs, seq[k]);
                end
            end
        end
    endtask

    task automatic test_branch();
        logic [2:0]  f3 [4];
        logic        eq [4];
        logic        lt [4];
        logic [24:0] ex [4];
        logic [24:0] seq [3];
        logic [24:0] base;
        base = PC_EN | imm_f(4'b0010) | A_SEL | B_SEL | wb_f(2'b01) | VLD;
        f3[0] = 3'b000; eq[0] = 1'b1; lt[0] = 1'b0; ex[0] = base | PC_SEL;
        f3[1] = 3'b001; eq[1] = 1'b1; lt[1] = 1'b1; ex[1] = base;
        f3[2] = 3'b110; eq[2] = 1'b0; lt[2] = 1'b0; ex[2] = base | BR_UN;
        f3[3] = 3'b101; eq[3] = 1'b1; lt[3] = 1'b0; ex[3] = base | PC_SEL;
        for (int n = 0; n < 4; n++) begin
            i_instr = ins(f3[n], OP_BRANCH);
            i_br_eq = eq[n];
            i_br_lt = lt[n];
            seq[0] = 25'h0; seq[1] = ex[n]; seq[2] = V_F;
            for (int k = 0; k < 3; k++) begin
                step();
                checks++;
                if (outs !== seq[k]) begin
                    failures++;
                    $display("FAIL branch n%0d cyc%0d got=%h exp=%h", n, k, outs, seq[k]);
                end
            end
        end
        i_br_eq = 1'b0;
        i_br_lt = 1'b0;
    endtask

    task automatic test_load();
        logic [2:0]  f3 [2];
        logic [24:0] ex [2];
        logic [24:0] seq [5];
        f3[0] = 3'b100; ex[0] = B_SEL | lt_f(4'b0001);
        f3[1] = 3'b001; ex[1] = B_SEL | lt_f(4'b0011) | LSGN;
        i_mem_ack = 1'b1;
        for (int n = 0; n < 2; n++) begin
            i_instr = ins(f3[n], OP_LOAD);
            seq[0] = 25'h0; seq[1] = ex[n]; seq[2] = ex[n]; seq[3] = ex[n] | RET; seq[4] = V_F;
            for (int k = 0; k < 5; k++) begin
                step();
                checks++;
                if (outs !== seq[k]) begin
                    failures++;
                    $display("FAIL load n%0d cyc%0d got=%h exp=%h", n, k, outs, seq[k]);
                end
            end
        end
        i_mem_ack = 1'b0;
    endtask

    task automatic test_store();
        logic [24:0] ex;
        logic [24:0] exp_v;
        ex = imm_f(4'b0001) | B_SEL | lt_f(4'b1111) | LSGN | wb_f(2'b01);
        i_instr = ins(3'b010, OP_STORE);
        i_mem_ack = 1'b0;
        step();
        checks++;
        if (outs !== 25'h0) begin failures++; $display("FAIL sw_decode got=%h exp=%h", outs, 25'h0); end
        step();
        checks++;
        if (outs !== ex) begin failures++; $display("FAIL sw_exec got=%h exp=%h", outs, ex); end
`ifdef CTRL_MEM_WAIT_EN
        for (int m = 1; m <= 3; m++) begin
            step();
            if (m == 3) begin i_mem_ack = 1'b1; #1; end
            exp_v = (m == 3) ? (ex | MEM_RW | PC_EN | VLD) : (ex | MEM_RW);
            checks++;
            if (outs !== exp_v) begin failures++; $display("FAIL sw_ack mem%0d got=%h exp=%h", m, outs, exp_v); end
        end
        step();
        i_mem_ack = 1'b0;
        checks++;
        if (outs !== V_F) begin failures++; $display("FAIL sw_ack_fetch got=%h exp=%h", outs, V_F); end
        step();
        step();
        checks++;
        if (outs !== ex) begin failures++; $display("FAIL sw_tmo_exec got=%h exp=%h", outs, ex); end
        for (int m = 1; m <= 4; m++) begin
            step();
            exp_v = (m == 4) ? (ex | MEM_RW | PC_EN | BERR) : (ex | MEM_RW);
            checks++;
            if (outs !== exp_v) begin failures++; $display("FAIL sw_tmo mem%0d got=%h exp=%h", m, outs, exp_v); end
        end
        step();
        checks++;
        if (outs !== V_F) begin failures++; $display("FAIL sw_tmo_fetch got=%h exp=%h", outs, V_F); end
`else
        step();
        exp_v = ex | MEM_RW | PC_EN | VLD;
        checks++;
        if (outs !== exp_v) begin failures++; $display("FAIL sw_mem got=%h exp=%h", outs, exp_v); end
        step();
        checks++;
        if (outs !== V_F) begin failures++; $display("FAIL sw_fetch got=%h exp=%h", outs, V_F); end
`endif
    endtask

    task automatic test_jump();
        logic [31:0] prog [2];
        logic [24:0] ex [2];
        logic [24:0] seq [4];
        prog[0] = ins(3'b000, OP_JAL);  ex[0] = imm_f(4'b0100) | A_SEL | B_SEL | wb_f(2'b10);
        prog[1] = ins(3'b000, OP_JALR); ex[1] = B_SEL | wb_f(2'b10);
        for (int n = 0; n < 2; n++) begin
            i_instr = prog[n];
            seq[0] = 25'h0; seq[1] = ex[n]; seq[2] = ex[n] | RET | PC_SEL; seq[3] = V_F;
            for (int k = 0; k < 4; k++) begin
                step();
                checks++;
                if (outs !== seq[k]) begin
                    failures++;
                    $display("FAIL jump n%0d cyc%0d got=%h exp=%h", n, k, outs, seq[k]);
                end
            end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] prog [2];
        prog[0] = ins(3'b000, 7'b0000000);
        prog[1] = ins(3'b010, OP_BRANCH);
        for (int n = 0; n < 2; n++) begin
            i_instr = prog[n];
            step();
            checks++;
            if (outs !== (PC_EN | ILL)) begin
                failures++;
                $display("FAIL illegal_decode n%0d got=%h exp=%h", n, outs, PC_EN | ILL);
            end
            step();
            checks++;
            if (outs !== V_F) begin failures++; $display("FAIL illegal_fetch n%0d got=%h exp=%h", n, outs, V_F); end
        end
    endtask

    task automatic test_reset_mid_wb();
        i_instr = ins(3'b000, OP_R);
        step();
        step();
        step();
        i_reset = 1'b0;
        #1;
        checks++;
        if (outs !== 25'h0) begin failures++; $display("FAIL rst_wb_async got=%h exp=%h", outs, 25'h0); end
        step();
        checks++;
        if (outs !== 25'h0) begin failures++; $display("FAIL rst_wb_hold got=%h exp=%h", outs, 25'h0); end
        #2 i_reset = 1'b1;
        #1;
        checks++;
        if (o_ir_en !== 1'b0) begin failures++; $display("FAIL rst_wb_release ir_en got=%b exp=0", o_ir_en); end
        step();
        checks++;
        if (outs !== V_F) begin failures++; $display("FAIL rst_wb_refetch got=%h exp=%h", outs, V_F); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_load();
        test_store();
        test_jump();
        test_illegal();
        test_reset_mid_wb();
        step();
        checks++;
        if (retired !== 13) begin failures++; $display("FAIL retire_count got=%0d exp=13", retired); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
